// File: rtl/cmos_nvram_io.sv
// HPS <-> CMOS NVRAM bridge: streams the 1024x4 CMOS image to/from the HPS ioctl port (index 4).
// Optional game-write dirty flag compiled in with `define CMOS_DIRTY_TRACK_EN.
module cmos_nvram_io (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        ioctl_download,
  input  logic        ioctl_upload,
  input  logic [15:0] ioctl_index,
  input  logic [24:0] ioctl_addr,
  input  logic        ioctl_wr,
  input  logic [7:0]  ioctl_dout,
  input  logic        ioctl_rd,
  output logic [7:0]  ioctl_din,
  output logic        ioctl_wait,
  output logic        cmos_sel,
  output logic [9:0]  cmos_addr,
  output logic [3:0]  cmos_din,
  output logic        cmos_we,
  input  logic [3:0]  cmos_dout,
  input  logic        core_cmos_we,
  output logic        dirty,
  output logic [1:0]  fsm_state
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RADDR = 2'd1,
    RDATA = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t state;
  logic   rd_oob;
  logic   idx_nvram;
  logic   addr_in_range;
  logic   rd_accept;
  logic   wr_accept;

  // Handshake: the HPS raises ioctl_rd for one cycle; ioctl_wait is high while the
  // byte is fetched and ioctl_din is valid in the first cycle ioctl_wait is low again.
  // Downloads are fire-and-forget: ioctl_wr is a one-cycle strobe, never stalled.
  assign idx_nvram     = (ioctl_index == 16'd4);
  assign addr_in_range = (ioctl_addr < 25'd1024);
  assign cmos_sel      = (ioctl_upload | ioctl_download) & idx_nvram;
  assign rd_accept     = ioctl_rd & ioctl_upload & ~ioctl_download & idx_nvram & (state == IDLE);
  assign wr_accept     = ioctl_wr & ioctl_download & idx_nvram & addr_in_range;
  assign fsm_state     = state;

  logic [3:0] unused_dout_hi;
  assign unused_dout_hi = ioctl_dout[7:4];

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state      <= IDLE;
      ioctl_wait <= 1'b0;
      ioctl_din  <= 8'h00;
      cmos_we    <= 1'b0;
      cmos_addr  <= 10'd0;
      cmos_din   <= 4'd0;
      rd_oob     <= 1'b0;
    end else begin
      cmos_we <= 1'b0;
      if (wr_accept) begin
        cmos_addr <= ioctl_addr[9:0];
        cmos_din  <= ioctl_dout[3:0];
        cmos_we   <= 1'b1;
      end

      // Losing the upload mid-byte abandons the fetch without touching ioctl_din.
      if (!ioctl_upload && state != IDLE) begin
        state      <= IDLE;
        ioctl_wait <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (rd_accept) begin
              cmos_addr  <= ioctl_addr[9:0];
              rd_oob     <= ~addr_in_range;
              ioctl_wait <= 1'b1;
              state      <= RADDR;
            end
          end
          RADDR: state <= RDATA;
          RDATA: begin
            ioctl_din  <= rd_oob ? 8'hFF : {4'hF, cmos_dout};
            ioctl_wait <= 1'b0;
            state      <= DONE;
          end
          DONE: begin
            ioctl_wait <= 1'b0;
            state      <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

`ifdef CMOS_DIRTY_TRACK_EN
  logic upload_q;
  logic dirty_q;

  // A game write in the same cycle as the upload ending keeps the flag set.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      upload_q <= 1'b0;
      dirty_q  <= 1'b0;
    end else begin
      upload_q <= ioctl_upload;
      if (core_cmos_we && !cmos_sel)
        dirty_q <= 1'b1;
      else if (upload_q && !ioctl_upload && idx_nvram)
        dirty_q <= 1'b0;
    end
  end

  assign dirty = dirty_q;
`else
  logic unused_core_we;
  assign unused_core_we = core_cmos_we;
  assign dirty          = 1'b0;
`endif

endmodule
